// File: rtl/kbd_pkg.sv
// kbd_pkg: shared FSM states, prefix codes and event field positions
package kbd_pkg;

    typedef enum logic [1:0] {POLL, READ, DECODE} kbd_state_t;

    localparam logic [7:0] KBD_EXT = 8'hE0;
    localparam logic [7:0] KBD_BRK = 8'hF0;

    localparam int EVT_BRK = 15;
    localparam int EVT_EXT = 14;

endpackage

// File: rtl/kbd_evt_fifo.sv
// kbd_evt_fifo: small synchronous FIFO with a registered head word
module kbd_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_d;
    logic [AW:0]   cnt, cnt_d;
    logic [W-1:0]  head_d;
    logic          do_push, do_pop;

    assign full  = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;

    // A full FIFO still accepts a push when the head leaves in the same cycle;
    // the head register looks ahead so it is valid right after the edge.
    always_comb begin
        do_push = push && (!full || pop);
        do_pop  = pop && !empty;
        rd_d    = rd_ptr + AW'(do_pop);
        cnt_d   = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        head_d  = (cnt_d == '0) ? '0 : (do_push && wr_ptr == rd_d) ? din : mem[rd_d];
    end

    // Storage array; contents are only observed through valid pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            head   <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_d;
            cnt    <= cnt_d;
            head   <= head_d;
        end
    end

endmodule

// File: rtl/kbd_event_ctrl.sv
// kbd_event_ctrl: polls the PS/2 receiver, folds E0/F0 prefixes and queues key events
module kbd_event_ctrl
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int PREFIX_TIMEOUT = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] kbd_dout,
    output logic        kbd_ack,
    output logic        evt_valid,
    output logic [15:0] evt_data,
    input  logic        evt_pop,
    output logic        evt_ovf,
    input  logic        ovf_clr
);

    localparam logic [15:0] TMO_LAST = 16'(PREFIX_TIMEOUT - 1);

    kbd_state_t  state, state_d;
    logic [7:0]  byte_q;
    logic        ext, brk;
    logic [15:0] tmo;
    logic        enter_read, expire, push, full, empty;
    logic [15:0] evt_in;
    logic        unused_hi;

    assign unused_hi = ^kbd_dout[15:8];

    // Next state, ack strobe, push decision and event assembly.
    always_comb begin
        state_d         = (state == POLL) ? (kbd_dout[0] ? READ : POLL)
                        : (state == READ) ? DECODE : POLL;
        kbd_ack         = state == READ;
        enter_read      = state == POLL && kbd_dout[0];
        expire          = state == POLL && (ext || brk) && tmo == TMO_LAST;
        push            = state == DECODE && byte_q != KBD_EXT && byte_q != KBD_BRK;
        evt_in          = {8'h00, byte_q};
        evt_in[EVT_BRK] = brk;
        evt_in[EVT_EXT] = ext;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= POLL;
        else        state <= state_d;
    end

    // Byte latch, prefix flags, prefix timeout and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q  <= '0;
            ext     <= 1'b0;
            brk     <= 1'b0;
            tmo     <= '0;
            evt_ovf <= 1'b0;
        end else begin
            if (state == READ) byte_q <= kbd_dout[7:0];
            if (state == DECODE) begin
                ext <= byte_q == KBD_EXT || (ext && byte_q == KBD_BRK);
                brk <= byte_q == KBD_BRK || (brk && byte_q == KBD_EXT);
            end else if (expire) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end
            if (enter_read || !(ext || brk) || expire) tmo <= '0;
            else if (state == POLL)                    tmo <= tmo + 16'd1;
            if (push && full && !evt_pop) evt_ovf <= 1'b1;
            else if (ovf_clr)             evt_ovf <= 1'b0;
        end
    end

    kbd_evt_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (evt_in),
        .pop   (evt_pop),
        .full  (full),
        .empty (empty),
        .head  (evt_data)
    );

    assign evt_valid = !empty;

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// tb_kbd_event_ctrl: directed vectors and corner sequences for kbd_event_ctrl
module tb_kbd_event_ctrl;

    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] kbd_dout;
    logic        kbd_ack;
    logic        evt_valid;
    logic [15:0] evt_data;
    logic        evt_pop = 1'b0;
    logic        evt_ovf;
    logic        ovf_clr = 1'b0;

    int          total = 0;
    int          bad = 0;
    int          ack_cnt = 0;
    int          rx_set = 0;
    int          rx_clr = 0;
    logic [7:0]  rx_code = 8'h00;

    typedef struct {
        logic [7:0]  b [3];
        int          n;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    // Receiver model: one pending byte, cleared on an acknowledged edge.
    assign kbd_dout = kbd_ack ? {8'h00, rx_code} : {15'b0, rx_set != rx_clr};

    always @(posedge clk) begin
        if (kbd_ack) begin
            rx_clr  <= rx_clr + 1;
            ack_cnt <= ack_cnt + 1;
        end
    end

    kbd_event_ctrl #(.FIFO_DEPTH(4), .PREFIX_TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .kbd_dout  (kbd_dout),
        .kbd_ack   (kbd_ack),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .evt_pop   (evt_pop),
        .evt_ovf   (evt_ovf),
        .ovf_clr   (ovf_clr)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_code = b;
        rx_set++;
        repeat (3) @(negedge clk);
    endtask

    task automatic pop_one;
        evt_pop = 1'b1;
        @(negedge clk);
        evt_pop = 1'b0;
    endtask

    initial begin
        int a0;
        vecs[0] = '{'{8'h1C, 8'h00, 8'h00}, 1, 16'h001C};
        vecs[1] = '{'{8'hF0, 8'h1C, 8'h00}, 2, 16'h801C};
        vecs[2] = '{'{8'hE0, 8'hF0, 8'h75}, 3, 16'hC075};
        vecs[3] = '{'{8'hE0, 8'h74, 8'h00}, 2, 16'h4074};
        vecs[4] = '{'{8'hE1, 8'h00, 8'h00}, 1, 16'h00E1};
        vecs[5] = '{'{8'hF0, 8'hE0, 8'h12}, 3, 16'hC012};

        repeat (2) @(negedge clk);
        chk("rst_ack", {15'b0, kbd_ack}, 16'h0);
        chk("rst_valid", {15'b0, evt_valid}, 16'h0);
        chk("rst_data", evt_data, 16'h0000);
        chk("rst_ovf", {15'b0, evt_ovf}, 16'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            a0 = ack_cnt;
            for (int k = 0; k < vecs[v].n; k++) begin
                send(vecs[v].b[k]);
                if (k < vecs[v].n - 1) chk($sformatf("v%0d_prefix_novalid", v), {15'b0, evt_valid}, 16'h0);
            end
            chk($sformatf("v%0d_acks", v), 16'(ack_cnt - a0), 16'(vecs[v].n));
            chk($sformatf("v%0d_valid", v), {15'b0, evt_valid}, 16'h1);
            chk($sformatf("v%0d_data", v), evt_data, vecs[v].exp);
            pop_one();
            chk($sformatf("v%0d_empty_valid", v), {15'b0, evt_valid}, 16'h0);
            chk($sformatf("v%0d_empty_data", v), evt_data, 16'h0000);
        end

        // Prefix timeout expires: extended flag is dropped.
        send(8'hE0);
        repeat (TMO) @(negedge clk);
        send(8'h1C);
        chk("tmo_expired", evt_data, 16'h001C);
        pop_one();

        // Prefix just short of the timeout survives.
        send(8'hE0);
        repeat (TMO - 3) @(negedge clk);
        send(8'h74);
        chk("tmo_kept", evt_data, 16'h4074);
        pop_one();

        // Overflow on a full FIFO, order preserved, then clear.
        for (int i = 1; i <= 5; i++) send(8'(i));
        chk("ovf_set", {15'b0, evt_ovf}, 16'h1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovf_pop%0d", i), evt_data, 16'(i));
            pop_one();
        end
        chk("ovf_drained", {15'b0, evt_valid}, 16'h0);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", {15'b0, evt_ovf}, 16'h0);

        // Push into a full FIFO coinciding with a pop.
        for (int i = 1; i <= 4; i++) send(8'(i));
        rx_code = 8'h05;
        rx_set++;
        repeat (2) @(negedge clk);
        pop_one();
        chk("full_pp_ovf", {15'b0, evt_ovf}, 16'h0);
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("full_pp_pop%0d", i), evt_data, 16'(i));
            pop_one();
        end
        chk("full_pp_drained", {15'b0, evt_valid}, 16'h0);

        // Push and pop together with one entry queued.
        send(8'h0A);
        rx_code = 8'h0B;
        rx_set++;
        repeat (2) @(negedge clk);
        pop_one();
        chk("pp1_valid", {15'b0, evt_valid}, 16'h1);
        chk("pp1_data", evt_data, 16'h000B);
        pop_one();
        chk("pp1_empty", {15'b0, evt_valid}, 16'h0);

        // Asynchronous reset while in READ with a prefix pending and an event queued.
        send(8'h11);
        send(8'hE0);
        rx_code = 8'h33;
        rx_set++;
        @(negedge clk);
        chk("rr_ack_before", {15'b0, kbd_ack}, 16'h1);
        rst_n = 1'b0;
        #1;
        chk("rr_ack_async", {15'b0, kbd_ack}, 16'h0);
        chk("rr_valid", {15'b0, evt_valid}, 16'h0);
        chk("rr_data", evt_data, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rr_held_valid", {15'b0, evt_valid}, 16'h1);
        chk("rr_held_data", evt_data, 16'h0033);
        pop_one();
        chk("rr_held_empty", {15'b0, evt_valid}, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kbd_event_ctrl.md
# kbd_event_ctrl

Controller that sequences the PS/2 keyboard receiver's status/ack port and turns raw scan-code bytes into decoded key events. It polls the receiver's status word, asserts the one-cycle read acknowledge, folds E0 (extended) and F0 (break) prefixes into the following code, and queues complete events in a small FIFO. The CPU-side I/O decoder pops events one at a time, so software never sees prefix bytes.

## Interface

- `FIFO_DEPTH`, 4: event queue depth; power of two, ≥2.
- `PREFIX_TIMEOUT`, 50000: clk cycles a pending prefix may wait for its code byte before it is discarded; 16-bit.
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `kbd_dout`  in  16  receiver output: status in bit 0 when `kbd_ack`=0; scan code in [7:0] when `kbd_ack`=1 (combinational).
- `kbd_ack`  out  1  receiver acknowledge/select.
- `evt_valid`  out  1  FIFO non-empty.
- `evt_data`  out  16  head event: [15] break, [14] extended, [13:8] zero, [7:0] scan code; 16'h0000 when empty.
- `evt_pop`  in  1  pop head event; ignored when empty.
- `evt_ovf`  out  1  sticky: an event was dropped on full FIFO.
- `ovf_clr`  in  1  clears `evt_ovf`.

## Operation

- Reset: state POLL, `kbd_ack`=0, prefix flags `ext`/`brk`=0, timeout counter 0, FIFO empty, `evt_valid`=0, `evt_data`=0, `evt_ovf`=0.
- FSM states:
  - POLL: `kbd_ack`=0. If `kbd_dout[0]`=1, go to READ. Otherwise stay.
  - READ: `kbd_ack`=1 for exactly this one cycle. Latch `kbd_dout[7:0]` into `byte_q`, then go to DECODE. The receiver clears its status on this same edge.
  - DECODE: `kbd_ack`=0.
    - `byte_q`=E0: set `ext`.
    - `byte_q`=F0: set `brk`.
    - Any other value, including E1: push {`brk`,`ext`,6'b0,`byte_q`} and clear both flags.
    - In all three cases, return to POLL.
- `kbd_ack` is never high in two consecutive cycles. At least two cycles separate acknowledges.
- Prefix timeout:
  - The counter runs while `ext|brk`=1 and the FSM is in POLL.
  - It resets to 0 on entry to READ, and whenever both flags are 0.
  - When it reaches `PREFIX_TIMEOUT`-1, the next edge clears both flags and the counter. Nothing is pushed.
- FIFO push on a full FIFO:
  - Without a pop in the same cycle: the event is dropped and `evt_ovf` is set.
  - With a pop in the same cycle: the push is accepted and count is unchanged.
- Simultaneous push and pop on a non-full FIFO: both happen and count is unchanged.
- Pop while empty: no effect.
- `ovf_clr` and a same-cycle drop: the set wins.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. Count is one bit wider.

## Timing

- Status seen in POLL to `kbd_ack` high: 1 cycle. READ to DECODE: 1 cycle.
- Byte to `evt_valid`: status=1 is sampled at edge N in POLL; the push edge is N+2. `evt_valid`/`evt_data` are updated after edge N+2, i.e. 3 edges after status rises.
- `evt_data` is registered from the FIFO head. It updates the cycle after a pop, with no combinational path from `evt_pop`.
- Asynchronous reset mid-sequence:
  - Drops `kbd_ack` immediately and any pending prefix.
  - A byte whose ack was never issued stays pending in the receiver and is read after reset release.

## Structure

- Package `kbd_pkg`:
  - FSM enum `kbd_state_t` (POLL, READ, DECODE).
  - Constants `KBD_EXT`=8'hE0, `KBD_BRK`=8'hF0.
  - Event field indices `EVT_BRK`=15, `EVT_EXT`=14.
- Sub-module `kbd_evt_fifo`: parameterised synchronous FIFO with push/pop/full/empty and registered head output. The controller owns the FSM, prefix flags, timeout and overflow flag.

## Test plan

- Status=1, code 8'h1C → exactly one `kbd_ack` pulse; then `evt_valid`=1, `evt_data`=16'h001C. After a pop, `evt_valid`=0 and `evt_data`=0.
- Bytes F0,1C → single event 16'h801C. Bytes E0,F0,75 → single event 16'hC075. No events are queued for the prefixes.
- E0, then no byte for `PREFIX_TIMEOUT` cycles, then 1C → event 16'h001C (ext cleared).
- FIFO_DEPTH=4: push 5 codes 01..05 with no pop → `evt_ovf`=1, and pops return 0001..0004 in order. Assert `ovf_clr` → `evt_ovf`=0.
- FIFO full and a push coincides with `evt_pop` → no overflow, count stays 4, and the last pop-out order is preserved.
- `rst_n` low during READ → `kbd_ack`=0 asynchronously, flags and FIFO cleared, `evt_valid`=0; the held byte is read after release.
